// File: rtl/pixel_write_queue_pkg.sv
// Shared widths, screen bounds and types for the pixel write queue.
// Everything that reads screen coordinates or colour imports this package.
package pixel_write_queue_pkg;
  localparam int SCR_WIDTH_BITS  = 8;
  localparam int SCR_HEIGHT_BITS = 7;
  localparam int COLOR_SIZE      = 3;
  localparam int SCR_WIDTH       = 160;
  localparam int SCR_HEIGHT      = 120;
  localparam int FIFO_AW         = 4;
  localparam logic [COLOR_SIZE-1:0] CLEAR_COLOR = '0;
  localparam int PIX_W = SCR_WIDTH_BITS + SCR_HEIGHT_BITS + COLOR_SIZE;

  typedef struct packed {
    logic [SCR_WIDTH_BITS-1:0]  x;
    logic [SCR_HEIGHT_BITS-1:0] y;
    logic [COLOR_SIZE-1:0]      color;
  } pixel_t;

  typedef enum logic {S_RUN = 1'b0, S_CLEAR = 1'b1} state_t;
endpackage

// File: rtl/pixel_write_queue_if.sv
// Painter-side inputs and VGA-adapter-side outputs of the pixel write queue.
interface pixel_write_queue_if;
  import pixel_write_queue_pkg::*;
  logic [SCR_WIDTH_BITS-1:0]  paint_x_co;
  logic [SCR_HEIGHT_BITS-1:0] paint_y_co;
  logic [COLOR_SIZE-1:0]      color;
  logic                       print_enable;
  logic                       clear_req;
  logic [SCR_WIDTH_BITS-1:0]  vga_x;
  logic [SCR_HEIGHT_BITS-1:0] vga_y;
  logic [COLOR_SIZE-1:0]      vga_colour;
  logic                       vga_plot;
  logic                       busy;
  logic                       clear_done;
  logic                       overflow;

  modport master (output paint_x_co, paint_y_co, color, print_enable, clear_req,
                  input  vga_x, vga_y, vga_colour, vga_plot, busy, clear_done, overflow);
  modport slave  (input  paint_x_co, paint_y_co, color, print_enable, clear_req,
                  output vga_x, vga_y, vga_colour, vga_plot, busy, clear_done, overflow);
endinterface

// File: rtl/pixel_write_queue_fifo.sv
// Synchronous FIFO of packed pixels; push while full is accepted only alongside a pop.
module pixel_fifo #(
  parameter int AW = 4,
  parameter int W  = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < (AW+1)'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/pixel_write_queue.sv
// Turns painter strobes into one queued write per pixel and drains them as vga_plot
// pulses; also runs a full-screen clear sweep that defers (not drops) queued pixels.
module pixel_write_queue
  import pixel_write_queue_pkg::*;
#(
  parameter int SCR_W = pixel_write_queue_pkg::SCR_WIDTH,
  parameter int SCR_H = pixel_write_queue_pkg::SCR_HEIGHT,
  parameter int AW    = pixel_write_queue_pkg::FIFO_AW
) (
  input  logic Clck,
  input  logic Reset,
  pixel_write_queue_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  state_t                     state, state_nxt;
  logic                       pe_q, cap, pop, drop, last, done_pend;
  logic [AW:0]                count, cnt_nxt;
  logic                       push_ok;
  pixel_t                     wpix, rpix;
  logic [SCR_WIDTH_BITS-1:0]  sx, vx;
  logic [SCR_HEIGHT_BITS-1:0] sy, vy;
  logic [COLOR_SIZE-1:0]      vc;
  logic                       plot, busy, clear_done, overflow;

  assign cap     = bus.print_enable && !pe_q;
  assign wpix    = '{x: bus.paint_x_co, y: bus.paint_y_co, color: bus.color};
  assign last    = (sx == SCR_WIDTH_BITS'(SCR_W-1)) && (sy == SCR_HEIGHT_BITS'(SCR_H-1));
  assign push_ok = cap && ((count < (AW+1)'(DEPTH)) || pop);
  assign drop    = cap && !push_ok;
  assign cnt_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop);

  pixel_fifo #(.AW(AW), .W(PIX_W)) u_fifo (
    .clk(Clck), .rst_n(Reset), .push(cap), .pop(pop),
    .wdata(wpix), .rdata(rpix), .count(count)
  );

  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) state <= S_RUN;
    else        state <= state_nxt;
  end

  // A clear request still lets the pop of that same cycle go out first.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_RUN: begin
        pop = (count != '0);
        if (bus.clear_req) state_nxt = S_CLEAR;
      end
      S_CLEAR: if (last) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge Clck or negedge Reset) begin
    if (!Reset) begin
      pe_q <= 1'b0; sx <= '0; sy <= '0;
      vx <= '0; vy <= '0; vc <= '0; plot <= 1'b0;
      done_pend <= 1'b0; clear_done <= 1'b0; busy <= 1'b0; overflow <= 1'b0;
    end else begin
      pe_q       <= bus.print_enable;
      plot       <= 1'b0;
      done_pend  <= 1'b0;
      clear_done <= done_pend;
      overflow   <= overflow | drop;
      busy       <= (cnt_nxt != '0) || (state_nxt == S_CLEAR);
      if (pop) begin
        vx <= rpix.x; vy <= rpix.y; vc <= rpix.color; plot <= 1'b1;
      end
      if (state == S_RUN && bus.clear_req) begin
        sx <= '0;
        sy <= '0;
      end
      if (state == S_CLEAR) begin
        vx <= sx; vy <= sy; vc <= CLEAR_COLOR; plot <= 1'b1;
        done_pend <= last;
        if (sx == SCR_WIDTH_BITS'(SCR_W-1)) begin
          sx <= '0;
          sy <= sy + 1'b1;
        end else begin
          sx <= sx + 1'b1;
        end
      end
    end
  end

  assign bus.vga_x      = vx;
  assign bus.vga_y      = vy;
  assign bus.vga_colour = vc;
  assign bus.vga_plot   = plot;
  assign bus.busy       = busy;
  assign bus.clear_done = clear_done;
  assign bus.overflow   = overflow;
endmodule

// File: tb/tb_pixel_write_queue.sv
// Randomized and directed bench for pixel_write_queue against a queue-based reference model.
module tb_pixel_write_queue;
  import pixel_write_queue_pkg::*;
  localparam int W = 8;
  localparam int H = 8;

  logic Clck, Reset;
  pixel_write_queue_if bus();

  pixel_write_queue #(.SCR_W(W), .SCR_H(H), .AW(4)) dut (.Clck(Clck), .Reset(Reset), .bus(bus));

  initial Clck = 1'b0;
  always #5 Clck = ~Clck;

  int errs = 0, checks = 0;
  int n_plot = 0, n_done = 0;

  // reference model state
  logic [PIX_W-1:0] m_q[$];
  bit   m_clr, m_pend, m_prev, m_ovf;
  int   m_idx;
  bit   e_plot, e_done, e_busy;
  logic [PIX_W-1:0] e_pix;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_clr = 0; m_pend = 0; m_prev = 0; m_ovf = 0; m_idx = 0;
    e_plot = 0; e_done = 0; e_busy = 0; e_pix = '0;
  endtask

  task automatic model_step();
    bit cap;
    cap = bus.print_enable && !m_prev;
    m_prev = bus.print_enable;
    e_done = m_pend; m_pend = 0; e_plot = 0;
    if (m_clr) begin
      e_plot = 1;
      e_pix  = {8'(m_idx % W), 7'(m_idx / W), CLEAR_COLOR};
      m_idx++;
      if (m_idx == W*H) begin m_clr = 0; m_pend = 1; end
    end else begin
      if (m_q.size() > 0) begin e_plot = 1; e_pix = m_q.pop_front(); end
      if (bus.clear_req) begin m_clr = 1; m_idx = 0; end
    end
    if (cap) begin
      if (m_q.size() < 16) m_q.push_back({bus.paint_x_co, bus.paint_y_co, bus.color});
      else m_ovf = 1;
    end
    e_busy = (m_q.size() != 0) || m_clr;
  endtask

  task automatic compare();
    chk("plot", 32'(bus.vga_plot), 32'(e_plot));
    chk("clear_done", 32'(bus.clear_done), 32'(e_done));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (e_plot) chk("pixel", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(e_pix));
    if (bus.vga_plot) n_plot++;
    if (bus.clear_done) n_done++;
  endtask

  task automatic step();
    @(posedge Clck);
    if (!Reset) model_reset(); else model_step();
    #1;
    compare();
  endtask

  task automatic drive(input bit pe, input bit clr);
    bus.print_enable = pe;
    bus.clear_req    = clr;
  endtask

  task automatic rnd_pix();
    bus.paint_x_co = 8'($urandom);
    bus.paint_y_co = 7'($urandom);
    bus.color      = 3'($urandom);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #1;
    model_reset();
    chk("rst_outputs", 32'({bus.vga_plot, bus.busy, bus.clear_done, bus.overflow,
                            bus.vga_x, bus.vga_y, bus.vga_colour}), 32'd0);
    step();
    Reset = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (n_done == 0 && g < 300) begin step(); g++; end
    chk(tag, 32'(g < 300), 32'd1);
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0);
    bus.paint_x_co = '0; bus.paint_y_co = '0; bus.color = '0;
    #1;
    do_reset();
    step();

    // single pixel from a 3-cycle strobe
    n_plot = 0;
    bus.paint_x_co = 8'd5; bus.paint_y_co = 7'd7; bus.color = 3'b001;
    drive(1, 0); repeat (3) step();
    drive(0, 0); repeat (4) step();
    chk("t1_plot_count", 32'(n_plot), 32'd1);

    // one sweep; a second clear_req mid-sweep is ignored
    n_plot = 0; n_done = 0;
    drive(0, 1); step();
    drive(0, 0); repeat (10) step();
    drive(0, 1); step();
    drive(0, 0);
    wait_done("t3_timeout");
    chk("t3_busy_at_done", 32'(bus.busy), 32'd0);
    repeat (4) step();
    chk("t3_plot_count", 32'(n_plot), 32'(W*H));
    chk("t3_done_count", 32'(n_done), 32'd1);

    // 20 captures during a sweep: 16 kept, 4 dropped
    n_plot = 0; n_done = 0;
    drive(0, 1); step();
    for (int i = 0; i < 20; i++) begin
      rnd_pix(); drive(1, 0); step();
      drive(0, 0); step();
    end
    wait_done("t2_timeout");
    repeat (20) step();
    chk("t2_plot_count", 32'(n_plot), 32'(W*H + 16));
    chk("t2_overflow", 32'(bus.overflow), 32'd1);

    // capture coinciding with the first pop from a full FIFO
    do_reset();
    n_plot = 0; n_done = 0;
    drive(0, 1); step();
    for (int i = 0; i < 16; i++) begin
      rnd_pix(); drive(1, 0); step();
      drive(0, 0); step();
    end
    begin
      int g = 0;
      while (m_clr && g < 200) begin step(); g++; end
      chk("t4_timeout", 32'(g < 200), 32'd1);
    end
    rnd_pix(); drive(1, 0); step();
    drive(0, 0); repeat (20) step();
    chk("t4_plot_count", 32'(n_plot), 32'(W*H + 17));
    chk("t4_overflow", 32'(bus.overflow), 32'd0);

    // async reset mid-sweep at pixel (3,1)
    do_reset();
    drive(0, 1); step();
    drive(0, 0);
    begin
      int g = 0;
      while (!(e_plot && e_pix == {8'd3, 7'd1, CLEAR_COLOR}) && g < 100) begin step(); g++; end
      chk("t5_timeout", 32'(g < 100), 32'd1);
    end
    n_plot = 0;
    do_reset();
    repeat (6) step();
    chk("t5_no_plot", 32'(n_plot), 32'd0);
    bus.paint_x_co = 8'd9; bus.paint_y_co = 7'd2; bus.color = 3'd6;
    drive(1, 0); step();
    drive(0, 0); repeat (3) step();
    chk("t5_run_plot", 32'(n_plot), 32'd1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rnd_pix();
      drive(($urandom % 3) == 0, ($urandom % 70) == 0);
      step();
    end
    drive(0, 0);
    repeat (120) step();
    chk("rand_drained", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
